psu_multi_ch_timer: RTL and testbench
=====================================

// Module: psu_multi_ch_timer
// PURPOSE
//  Multi-channel, parametrised successor to the single PSU-on delay counter.
//  - NUM_CH independent timers share the 2 MHz reference clock iClk.
//  - Each channel picks one of four timeouts, latched at start.
//  - Modes: one-shot (level done held) or periodic (1-cycle pulse, auto-restart).
//  - Sits in the PSU-on control path; sequencer FSMs use it for ramp and PWRGD
//    timeouts instead of one counter instance per delay.
// PARAMETERS
//  NUM_CH   4        number of independent channels (1..16)
//  CNT_W    22       counter width; must hold the largest Tn
//  T0       100000   timeout sel=0, in iClk ticks (50 ms @ 2 MHz)
//  T1       200000   timeout sel=1 (100 ms)
//  T2       1000000  timeout sel=2 (500 ms)
//  T3       2000000  timeout sel=3 (1 s)
// PORTS
//  iClk        in   1          2 MHz reference clock
//  iRst_n      in   1          reset, asynchronous, active-low
//  iEnable     in   NUM_CH     per-channel run request; low = clear channel
//  iSel        in   2*NUM_CH   timeout select, ch n = iSel[2n+1:2n]
//  iPeriodic   in   NUM_CH     1 = periodic mode, 0 = one-shot; latched at start
//  oDone       out  NUM_CH     one-shot: level until iEnable low; periodic: pulse
//  oDonePulse  out  NUM_CH     1-cycle pulse on every expiry, both modes
//  oBusy       out  1          OR of all channels in COUNT
// BEHAVIOUR
//  - Reset: all channels IDLE; cnt=0; oDone=0, oDonePulse=0, oBusy=0.
//  - Per-channel FSM states: IDLE, COUNT, DONE. Channels are fully independent.
//  - IDLE: iEnable=1 sampled at edge E moves the channel to COUNT.
//    At E: cnt<=0; tgt<=T[iSel]; mode<=iPeriodic.
//  - COUNT, each edge:
//    - cnt==tgt-1: expire. oDonePulse=1 for that cycle.
//    - one-shot expire: ->DONE, oDone=1.
//    - periodic expire: cnt<=0, stay in COUNT, oDone pulses 1 cycle.
//    - otherwise cnt<=cnt+1.
//    - First expiry registers at edge E+tgt; periodic expiries repeat every tgt
//      cycles.
//  - DONE: oDone held 1 while iEnable=1. No further pulses; cnt frozen.
//  - iEnable=0 in any state: ->IDLE, cnt<=0, oDone<=0 at next edge, no pulse.
//    This has priority over an expiry on the same edge.
//  - Restart: iEnable must be seen low for >=1 edge before a new run. Holding
//    iEnable high never retriggers a one-shot channel.
//  - iSel/iPeriodic changes during COUNT/DONE are ignored until the next IDLE->COUNT.
//  - Arithmetic: unsigned CNT_W, no wrap (cnt<tgt always).
//    Elaboration error if any Tn==0 or Tn>=2**CNT_W.
//  - Async reset mid-count aborts immediately; outputs go low with no glitch
//    pulse after release.
//  - All outputs registered; no combinational path from inputs to outputs.
//    oBusy is registered, aligned with state.
// STRUCTURE
//  - Shared package psu_timer_pkg:
//    - channel state encoding (IDLE/COUNT/DONE);
//    - default tick constants for 2 MHz (T_50MS, T_100MS, T_500MS, T_1S);
//    - select encoding.
//  - Sub-module psu_ch_timer: one channel (FSM + CNT_W counter + target mux),
//    instantiated NUM_CH times by generate.
//  - Top level holds only the generate loop and the oBusy reduction.
// TESTING  (bench overrides T0=4, T1=8, T2=16, T3=3, NUM_CH=4)
//  1. ch0 sel=0 one-shot, iEnable 0->1 at edge E
//     -> oDonePulse[0] only at E+4; oDone[0]=1 from E+4 while enabled; oBusy
//        high E..E+3.
//  2. ch1 sel=3 periodic, enable held 20 cycles
//     -> oDonePulse[1]/oDone[1] 1-cycle pulses at E+3, E+6, E+9, ...;
//        oBusy stays 1.
//  3. ch2 sel=1, drop iEnable at E+5
//     -> no pulse, oDone[2]=0, cnt=0. Re-enable -> expiry 8 edges after new start.
//  4. ch0 sel=0 started, iSel changed to 2 at E+1
//     -> still expires at E+4 (latched). Next run uses T2=16.
//  5. iEnable dropped exactly on expiry edge
//     -> no oDonePulse, channel IDLE.
//  6. all 4 channels staggered starts, iRst_n pulsed low mid-count
//     -> all outputs 0 immediately; nothing fires until re-enabled after
//        reset release.

Source files
------------

// File: rtl/psu_timer_pkg.sv
// Shared definitions for the PSU multi-channel timer.
//   - ch_state_t : per-channel state encoding
//   - T_*        : default timeouts in ticks of the 2 MHz reference clock
//   - SEL_*      : timeout select encoding (2-bit)
package psu_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } ch_state_t;

  localparam int T_50MS  = 100000;
  localparam int T_100MS = 200000;
  localparam int T_500MS = 1000000;
  localparam int T_1S    = 2000000;

  localparam logic [1:0] SEL_T0 = 2'd0;
  localparam logic [1:0] SEL_T1 = 2'd1;
  localparam logic [1:0] SEL_T2 = 2'd2;
  localparam logic [1:0] SEL_T3 = 2'd3;

endpackage

// File: rtl/psu_ch_timer.sv
// One timer channel: IDLE/COUNT/DONE FSM, up-counter and latched target.
// Ports:
//   iClk, iRst_n     clock, async active-low reset
//   iEnable          run request; low clears the channel
//   iSel             timeout select, latched on IDLE->COUNT
//   iPeriodic        1 = auto-restart on expiry, latched on IDLE->COUNT
//   oDone            one-shot: level in DONE; periodic: 1-cycle pulse
//   oDonePulse       1-cycle pulse on every expiry
//   oCountNext       next-state is COUNT (registered by the top into oBusy)
//
// state | meaning
// IDLE  | cleared, waiting for iEnable
// COUNT | counting toward the latched target
// DONE  | one-shot expired, oDone held until iEnable drops
module psu_ch_timer
  import psu_timer_pkg::*;
#(
  parameter int CNT_W = 22,
  parameter int T0    = T_50MS,
  parameter int T1    = T_100MS,
  parameter int T2    = T_500MS,
  parameter int T3    = T_1S
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iEnable,
  input  logic [1:0] iSel,
  input  logic       iPeriodic,
  output logic       oDone,
  output logic       oDonePulse,
  output logic       oCountNext
);

  ch_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_tgt, w_tgt_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pulse, w_pulse_nxt;
  logic [CNT_W-1:0] w_sel_tgt;

  always_comb begin
    w_sel_tgt = CNT_W'(T0);
    case (iSel)
      SEL_T0:  w_sel_tgt = CNT_W'(T0);
      SEL_T1:  w_sel_tgt = CNT_W'(T1);
      SEL_T2:  w_sel_tgt = CNT_W'(T2);
      SEL_T3:  w_sel_tgt = CNT_W'(T3);
      default: w_sel_tgt = CNT_W'(T0);
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tgt_nxt   = r_tgt;
    w_mode_nxt  = r_mode;
    w_done_nxt  = 1'b0;
    w_pulse_nxt = 1'b0;
    // Dropping iEnable wins over an expiry on the same edge.
    if (!iEnable) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_COUNT;
          w_cnt_nxt   = '0;
          w_tgt_nxt   = w_sel_tgt;
          w_mode_nxt  = iPeriodic;
        end
        ST_COUNT: begin
          // Target is never zero, so tgt-1 cannot underflow.
          if (r_cnt == r_tgt - CNT_W'(1)) begin
            w_pulse_nxt = 1'b1;
            w_done_nxt  = 1'b1;
            if (r_mode) w_cnt_nxt = '0;
            else        w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: w_done_nxt = 1'b1;
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_tgt   <= '0;
      r_mode  <= 1'b0;
      r_done  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tgt   <= w_tgt_nxt;
      r_mode  <= w_mode_nxt;
      r_done  <= w_done_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  assign oDone      = r_done;
  assign oDonePulse = r_pulse;
  assign oCountNext = (w_state_nxt == ST_COUNT);

endmodule

// File: rtl/psu_multi_ch_timer.sv
// NUM_CH independent PSU timers sharing the 2 MHz reference clock.
// Ports:
//   iClk, iRst_n   clock, async active-low reset
//   iEnable        per-channel run request
//   iSel           per-channel timeout select, ch n = iSel[2n+1:2n]
//   iPeriodic      per-channel periodic mode
//   oDone          per-channel done (level or pulse, see psu_ch_timer)
//   oDonePulse     per-channel expiry pulse
//   oBusy          registered OR of all channels in COUNT
module psu_multi_ch_timer
  import psu_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 22,
  parameter int T0     = T_50MS,
  parameter int T1     = T_100MS,
  parameter int T2     = T_500MS,
  parameter int T3     = T_1S
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic [NUM_CH-1:0]   iEnable,
  input  logic [2*NUM_CH-1:0] iSel,
  input  logic [NUM_CH-1:0]   iPeriodic,
  output logic [NUM_CH-1:0]   oDone,
  output logic [NUM_CH-1:0]   oDonePulse,
  output logic                oBusy
);

  localparam longint LIM = longint'(1) << CNT_W;

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("psu_multi_ch_timer: NUM_CH must be 1..16");
  end
  if (T0 <= 0 || T1 <= 0 || T2 <= 0 || T3 <= 0) begin : g_bad_t_zero
    $error("psu_multi_ch_timer: timeouts must be non-zero");
  end
  if (longint'(T0) >= LIM || longint'(T1) >= LIM ||
      longint'(T2) >= LIM || longint'(T3) >= LIM) begin : g_bad_t_wide
    $error("psu_multi_ch_timer: timeout does not fit CNT_W");
  end

  logic [NUM_CH-1:0] w_count_nxt;
  logic              r_busy;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    psu_ch_timer #(
      .CNT_W (CNT_W),
      .T0    (T0),
      .T1    (T1),
      .T2    (T2),
      .T3    (T3)
    ) u_ch (
      .iClk       (iClk),
      .iRst_n     (iRst_n),
      .iEnable    (iEnable[g]),
      .iSel       (iSel[2*g +: 2]),
      .iPeriodic  (iPeriodic[g]),
      .oDone      (oDone[g]),
      .oDonePulse (oDonePulse[g]),
      .oCountNext (w_count_nxt[g])
    );
  end

  // Registered from the channels' next state so oBusy lines up with state.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_busy <= 1'b0;
    else         r_busy <= |w_count_nxt;
  end

  assign oBusy = r_busy;

endmodule

// File: tb/tb_psu_multi_ch_timer.sv
module tb_psu_multi_ch_timer;

  logic       iClk = 1'b0;
  logic       iRst_n;
  logic [3:0] iEnable;
  logic [7:0] iSel;
  logic [3:0] iPeriodic;
  logic [3:0] oDone;
  logic [3:0] oDonePulse;
  logic       oBusy;

  int total = 0;
  int bad   = 0;

  psu_multi_ch_timer #(
    .NUM_CH (4),
    .CNT_W  (22),
    .T0     (4),
    .T1     (8),
    .T2     (16),
    .T3     (3)
  ) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iEnable    (iEnable),
    .iSel       (iSel),
    .iPeriodic  (iPeriodic),
    .oDone      (oDone),
    .oDonePulse (oDonePulse),
    .oBusy      (oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int k, input int pulse, input int done, input int busy);
    chk($sformatf("%s_k%0d_pulse", tag, k), int'(oDonePulse), pulse);
    chk($sformatf("%s_k%0d_done", tag, k), int'(oDone), done);
    chk($sformatf("%s_k%0d_busy", tag, k), int'(oBusy), busy);
  endtask

  initial begin
    iRst_n    = 1'b0;
    iEnable   = '0;
    iSel      = '0;
    iPeriodic = '0;
    #2;
    chk_all("rst_hold", 0, 0, 0, 0);
    tick();
    tick();
    iRst_n = 1'b1;
    tick();
    chk_all("rst_rel", 0, 0, 0, 0);

    // 1: ch0 sel=0 (T=4) one-shot
    iSel[1:0] = 2'd0; iPeriodic[0] = 1'b0; iEnable[0] = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick();
      chk_all("t1", k, (k == 4) ? 1 : 0, (k >= 4) ? 1 : 0, (k < 4) ? 1 : 0);
    end
    iEnable[0] = 1'b0;
    tick();
    chk_all("t1_off", 0, 0, 0, 0);

    // 2: ch1 sel=3 (T=3) periodic
    iSel[3:2] = 2'd3; iPeriodic[1] = 1'b1; iEnable[1] = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      tick();
      chk_all("t2", k, (k > 0 && k % 3 == 0) ? 2 : 0, (k > 0 && k % 3 == 0) ? 2 : 0, 1);
    end
    iEnable[1] = 1'b0; iPeriodic[1] = 1'b0;
    tick();
    chk_all("t2_off", 0, 0, 0, 0);

    // 3: ch2 sel=1 (T=8), abort at E+5, then a clean restart
    iSel[5:4] = 2'd1; iEnable[2] = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      tick();
      chk_all("t3a", k, 0, 0, 1);
    end
    iEnable[2] = 1'b0;
    for (int k = 5; k <= 10; k++) begin
      tick();
      chk_all("t3b", k, 0, 0, 0);
    end
    iEnable[2] = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      tick();
      chk_all("t3c", k, (k == 8) ? 4 : 0, (k >= 8) ? 4 : 0, (k < 8) ? 1 : 0);
    end
    iEnable[2] = 1'b0;
    tick();

    // 4: ch0 sel=0 started, sel changed to 2 after start
    iSel[1:0] = 2'd0; iEnable[0] = 1'b1;
    tick();
    chk_all("t4a", 0, 0, 0, 1);
    iSel[1:0] = 2'd2;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all("t4a", k, (k == 4) ? 1 : 0, (k >= 4) ? 1 : 0, (k < 4) ? 1 : 0);
    end
    iEnable[0] = 1'b0;
    tick();
    iEnable[0] = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      tick();
      chk_all("t4b", k, (k == 16) ? 1 : 0, (k >= 16) ? 1 : 0, (k < 16) ? 1 : 0);
    end
    iEnable[0] = 1'b0;
    tick();

    // 5: ch0 sel=0, enable dropped on the expiry edge
    iSel[1:0] = 2'd0;
    iEnable[0] = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      tick();
      chk_all("t5a", k, 0, 0, 1);
    end
    iEnable[0] = 1'b0;
    for (int k = 4; k <= 7; k++) begin
      tick();
      chk_all("t5b", k, 0, 0, 0);
    end

    // 6: staggered starts then async reset mid-count
    iSel = {2'd2, 2'd2, 2'd1, 2'd2};
    iPeriodic = '0;
    for (int c = 0; c < 4; c++) begin
      iEnable[c] = 1'b1;
      tick();
      chk_all("t6_start", c, 0, 0, 1);
    end
    iRst_n = 1'b0;
    #1;
    chk_all("t6_rst_now", 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("t6_rst", k, 0, 0, 0);
    end
    iEnable = '0;
    #2;
    iRst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk_all("t6_quiet", k, 0, 0, 0);
    end
    iEnable[1] = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      tick();
      chk_all("t6_re", k, (k == 8) ? 2 : 0, (k >= 8) ? 2 : 0, (k < 8) ? 1 : 0);
    end
    iEnable = '0;
    tick();
    chk_all("t6_end", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
